// File: rtl/ddr_burst_frame_writer.sv
// ddr_burst_frame_writer: packs a valid/ready pixel stream into MIG port-0 write
// bursts and ping-pongs complete frames between two DDR buffers.
module ddr_burst_frame_writer #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       BURST_LEN   = 64,
    parameter int unsigned       FIFO_DEPTH  = 64,
    parameter int unsigned       ADDR_W      = 30,
    parameter int unsigned       FRAME_WORDS = 70560,
    parameter logic [ADDR_W-1:0] FRAME0_BASE = '0,
    parameter logic [ADDR_W-1:0] FRAME1_BASE = ADDR_W'(32'h80000)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  calib_done,
    input  logic                  p0_wr_full,
    input  logic                  p0_wr_empty,
    input  logic                  p0_cmd_full,
    output logic                  p0_wr_en,
    output logic [DATA_W-1:0]     p0_wr_data,
    output logic [DATA_W/8-1:0]   p0_wr_mask,
    output logic                  p0_cmd_en,
    output logic [2:0]            p0_cmd_instr,
    output logic [5:0]            p0_cmd_bl,
    output logic [ADDR_W-1:0]     p0_cmd_byte_addr,
    output logic                  wr_frame,
    output logic                  done_frame,
    output logic                  frame_done,
    output logic                  overrun_err,
    output logic                  calib_lost_err,
    output logic [2:0]            state_dbg
);
    // A burst can never exceed what the MIG write FIFO holds.
    localparam int unsigned BURST_MAX  = (BURST_LEN < FIFO_DEPTH) ? BURST_LEN : FIFO_DEPTH;
    localparam int unsigned BCNT_W     = $clog2(BURST_MAX + 1);
    localparam int unsigned WPTR_W     = $clog2(FRAME_WORDS + 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        WAIT_CAL = 3'd0,
        FILL     = 3'd1,
        CMD      = 3'd2,
        DRAIN    = 3'd3,
        SWAP     = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic                cal_meta, cal_sync;
    logic [BCNT_W-1:0]   bcnt, bcnt_inc;
    logic [WPTR_W-1:0]   wptr, wptr_inc, bstart;
    logic                last_seen;
    logic                accept, hit_limit;
    logic                set_last, set_ovr, cmd_go, swap, cal_lost;
    logic [ADDR_W-1:0]   frame_base;

    // Zero-latency write path straight into the MIG write FIFO.
    assign s_ready      = (state == FILL) & ~p0_wr_full & (bcnt < BCNT_W'(BURST_MAX)) & ~last_seen;
    assign accept       = s_valid & s_ready;
    assign p0_wr_en     = accept;
    assign p0_wr_data   = s_data;
    assign p0_wr_mask   = '0;
    assign p0_cmd_instr = 3'b000;
    assign state_dbg    = state;

    assign bcnt_inc   = bcnt + BCNT_W'(1);
    assign wptr_inc   = wptr + WPTR_W'(1);
    assign hit_limit  = (wptr_inc == WPTR_W'(FRAME_WORDS));
    assign frame_base = wr_frame ? FRAME1_BASE : FRAME0_BASE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_CAL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        set_last  = 1'b0;
        set_ovr   = 1'b0;
        cmd_go    = 1'b0;
        swap      = 1'b0;
        cal_lost  = 1'b0;
        case (state)
            WAIT_CAL: if (cal_sync) state_nxt = FILL;
            FILL: begin
                if (accept) begin
                    if (s_last || hit_limit) begin
                        set_last  = 1'b1;
                        state_nxt = CMD;
                    end
                    if (hit_limit && !s_last) set_ovr = 1'b1;
                    if (bcnt_inc == BCNT_W'(BURST_MAX)) state_nxt = CMD;
                end
            end
            CMD: begin
                if (!p0_cmd_full) begin
                    cmd_go    = 1'b1;
                    state_nxt = last_seen ? DRAIN : FILL;
                end
            end
            DRAIN: if (p0_wr_empty) state_nxt = SWAP;
            SWAP: begin
                swap      = 1'b1;
                state_nxt = FILL;
            end
            default: state_nxt = WAIT_CAL;
        endcase
        // Losing calibration abandons the partial frame from any active state.
        if (state != WAIT_CAL && !cal_sync) begin
            cal_lost  = 1'b1;
            state_nxt = WAIT_CAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_meta         <= 1'b0;
            cal_sync         <= 1'b0;
            bcnt             <= '0;
            wptr             <= '0;
            bstart           <= '0;
            last_seen        <= 1'b0;
            p0_cmd_en        <= 1'b0;
            p0_cmd_bl        <= '0;
            p0_cmd_byte_addr <= '0;
            wr_frame         <= 1'b0;
            done_frame       <= 1'b0;
            frame_done       <= 1'b0;
            overrun_err      <= 1'b0;
            calib_lost_err   <= 1'b0;
        end else begin
            cal_meta   <= calib_done;
            cal_sync   <= cal_meta;
            p0_cmd_en  <= 1'b0;
            frame_done <= 1'b0;
            if (cal_lost) begin
                calib_lost_err <= 1'b1;
                bcnt           <= '0;
                wptr           <= '0;
                bstart         <= '0;
                last_seen      <= 1'b0;
            end else begin
                if (accept) begin
                    bcnt <= bcnt_inc;
                    wptr <= wptr_inc;
                end
                if (set_last) last_seen   <= 1'b1;
                if (set_ovr)  overrun_err <= 1'b1;
                if (cmd_go) begin
                    p0_cmd_en        <= 1'b1;
                    p0_cmd_bl        <= 6'(bcnt - BCNT_W'(1));
                    p0_cmd_byte_addr <= frame_base + ADDR_W'(bstart) * WORD_BYTES;
                    bcnt             <= '0;
                    bstart           <= wptr;
                end
                if (swap) begin
                    done_frame <= wr_frame;
                    wr_frame   <= ~wr_frame;
                    frame_done <= 1'b1;
                    wptr       <= '0;
                    bstart     <= '0;
                    last_seen  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_burst_frame_writer.sv
// Bench for ddr_burst_frame_writer: random pixel streams checked against a
// frame-level model of the expected bursts, data order and frame bookkeeping.
`timescale 1ns/1ps
module tb_ddr_burst_frame_writer;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BURST_LEN   = 64;
    localparam int unsigned FIFO_DEPTH  = 64;
    localparam int unsigned ADDR_W      = 30;
    localparam int unsigned FRAME_WORDS = 160;
    localparam int unsigned BYTES       = DATA_W / 8;
    localparam int unsigned CMD_W       = 6 + ADDR_W;
    localparam logic [ADDR_W-1:0] F0    = 30'h0;
    localparam logic [ADDR_W-1:0] F1    = 30'h80000;

    logic                clk, rst_n;
    logic [DATA_W-1:0]   s_data;
    logic                s_valid, s_last, s_ready;
    logic                calib_done, p0_wr_full, p0_wr_empty, p0_cmd_full;
    logic                p0_wr_en, p0_cmd_en;
    logic [DATA_W-1:0]   p0_wr_data;
    logic [DATA_W/8-1:0] p0_wr_mask;
    logic [2:0]          p0_cmd_instr, state_dbg;
    logic [5:0]          p0_cmd_bl;
    logic [ADDR_W-1:0]   p0_cmd_byte_addr;
    logic                wr_frame, done_frame, frame_done, overrun_err, calib_lost_err;

    ddr_burst_frame_writer #(
        .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W),
        .FRAME_WORDS(FRAME_WORDS), .FRAME0_BASE(F0), .FRAME1_BASE(F1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .calib_done(calib_done), .p0_wr_full(p0_wr_full),
        .p0_wr_empty(p0_wr_empty), .p0_cmd_full(p0_cmd_full), .p0_wr_en(p0_wr_en),
        .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask), .p0_cmd_en(p0_cmd_en),
        .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
        .p0_cmd_byte_addr(p0_cmd_byte_addr), .wr_frame(wr_frame), .done_frame(done_frame),
        .frame_done(frame_done), .overrun_err(overrun_err), .calib_lost_err(calib_lost_err),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_data[$], got_data[$];
    logic [CMD_W-1:0]  exp_cmd[$],  got_cmd[$];
    int   exp_fd = 0, got_fd = 0;

    // Reference model state: frame-level view of the ping-pong buffers.
    logic m_buf = 1'b0, m_done_buf = 1'b0, m_ovr = 1'b0;
    int   m_pending = 0;

    always @(negedge clk) begin
        if (p0_wr_en)   got_data.push_back(p0_wr_data);
        if (p0_cmd_en)  got_cmd.push_back({p0_cmd_bl, p0_cmd_byte_addr});
        if (frame_done) got_fd++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A complete frame of L words splits into BURST_LEN chunks from the buffer base.
    task automatic model_close(input int len);
        logic [ADDR_W-1:0] base;
        int                n;
        base = m_buf ? F1 : F0;
        for (int off = 0; off < len; off += BURST_LEN) begin
            n = ((len - off) < BURST_LEN) ? (len - off) : BURST_LEN;
            exp_cmd.push_back({6'(n - 1), base + ADDR_W'(off * BYTES)});
        end
        m_done_buf = m_buf;
        m_buf      = ~m_buf;
        exp_fd++;
    endtask

    task automatic model_words(input int n, input bit last);
        int t;
        t = m_pending + n;
        while (t > FRAME_WORDS || (t == FRAME_WORDS && !last)) begin
            model_close(FRAME_WORDS);
            m_ovr = 1'b1;
            t -= FRAME_WORDS;
        end
        if (last) begin
            model_close(t);
            t = 0;
        end
        m_pending = t;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            tick();
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("accept_in_time", 64'(ok), 64'(1));
        if (ok) exp_data.push_back(d);
    endtask

    // Streams n random words; optional write-FIFO stall and command-FIFO stall points.
    task automatic send_frame(input int n, input bit last, input int stall_at, input int cmdfull_at);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) tick();
            if (i == stall_at) begin
                p0_wr_full = 1'b1;
                s_valid    = 1'b1;
                s_data     = d;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("stall_s_ready", 64'(s_ready), 64'(0));
                    chk("stall_wr_en", 64'(p0_wr_en), 64'(0));
                    tick();
                end
                p0_wr_full = 1'b0;
            end
            if (i == cmdfull_at) p0_cmd_full = 1'b1;
            send_word(d, last && (i == n - 1));
            if (i == cmdfull_at) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("cmdfull_state", 64'(state_dbg), 64'(2));
                    chk("cmdfull_cmd_en", 64'(p0_cmd_en), 64'(0));
                    chk("cmdfull_s_ready", 64'(s_ready), 64'(0));
                    tick();
                end
                p0_cmd_full = 1'b0;
                @(negedge clk);
                chk("cmdfull_release_pre", 64'(p0_cmd_en), 64'(0));
                tick();
                @(negedge clk);
                chk("cmdfull_release_pulse", 64'(p0_cmd_en), 64'(1));
                tick();
            end
        end
        model_words(n, last);
    endtask

    task automatic wait_frames();
        int n;
        n = 0;
        while (got_fd < exp_fd && n < 500) begin
            tick();
            n++;
        end
        chk("frame_done_count", 64'(got_fd), 64'(exp_fd));
        repeat (4) tick();
    endtask

    task automatic cmp_all(input string tag);
        int nc, nd;
        chk({tag, "_ncmd"}, 64'(got_cmd.size()), 64'(exp_cmd.size()));
        chk({tag, "_ndata"}, 64'(got_data.size()), 64'(exp_data.size()));
        nc = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
        nd = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < nc; i++) chk({tag, "_cmd"}, 64'(got_cmd[i]), 64'(exp_cmd[i]));
        for (int i = 0; i < nd; i++) chk({tag, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
        chk({tag, "_wr_frame"}, 64'(wr_frame), 64'(m_buf));
        chk({tag, "_done_frame"}, 64'(done_frame), 64'(m_done_buf));
        chk({tag, "_overrun"}, 64'(overrun_err), 64'(m_ovr));
        got_cmd.delete();
        exp_cmd.delete();
        got_data.delete();
        exp_data.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'(0));
        chk({tag, "_wr_en"}, 64'(p0_wr_en), 64'(0));
        chk({tag, "_cmd_en"}, 64'(p0_cmd_en), 64'(0));
        chk({tag, "_cmd_bl"}, 64'(p0_cmd_bl), 64'(0));
        chk({tag, "_cmd_addr"}, 64'(p0_cmd_byte_addr), 64'(0));
        chk({tag, "_cmd_instr"}, 64'(p0_cmd_instr), 64'(0));
        chk({tag, "_wr_mask"}, 64'(p0_wr_mask), 64'(0));
        chk({tag, "_wr_frame"}, 64'(wr_frame), 64'(0));
        chk({tag, "_done_frame"}, 64'(done_frame), 64'(0));
        chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
        chk({tag, "_overrun"}, 64'(overrun_err), 64'(0));
        chk({tag, "_calib_lost"}, 64'(calib_lost_err), 64'(0));
        chk({tag, "_state"}, 64'(state_dbg), 64'(0));
    endtask

    initial begin
        rst_n       = 1'b0;
        s_data      = '0;
        s_valid     = 1'b0;
        s_last      = 1'b0;
        calib_done  = 1'b0;
        p0_wr_full  = 1'b0;
        p0_wr_empty = 1'b1;
        p0_cmd_full = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        calib_done = 1'b1;
        repeat (5) tick();
        chk("calib_to_fill", 64'(state_dbg), 64'(1));

        // 128 words ending exactly on a burst boundary.
        send_frame(128, 1'b1, -1, -1);
        wait_frames();
        cmp_all("t1");

        // 100 words: partial flush, DRAIN held until the write FIFO empties.
        p0_wr_empty = 1'b0;
        send_frame(100, 1'b1, -1, -1);
        repeat (10) tick();
        @(negedge clk);
        chk("drain_hold_state", 64'(state_dbg), 64'(3));
        chk("drain_hold_no_done", 64'(got_fd), 64'(exp_fd - 1));
        tick();
        p0_wr_empty = 1'b1;
        wait_frames();
        cmp_all("t2");

        for (int r = 0; r < 3; r++) begin
            send_frame($urandom_range(1, 150), 1'b1, -1, -1);
            wait_frames();
            cmp_all("rand");
        end

        // Write-FIFO full stall at word 30 of a single full burst.
        send_frame(64, 1'b1, 29, -1);
        wait_frames();
        cmp_all("t3");

        // Command-FIFO full while the first burst waits in CMD.
        send_frame(70, 1'b1, -1, 63);
        wait_frames();
        cmp_all("t4");

        // No s_last: word FRAME_WORDS closes the frame and flags overrun.
        send_frame(FRAME_WORDS + 20, 1'b0, -1, -1);
        wait_frames();
        chk("overrun_sticky", 64'(overrun_err), 64'(1));
        send_frame(10, 1'b1, -1, -1);
        wait_frames();
        cmp_all("t5");

        // Calibration loss mid-burst abandons the partial frame.
        send_frame(20, 1'b0, -1, -1);
        m_pending = 0;
        calib_done = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("calib_lost_err", 64'(calib_lost_err), 64'(1));
        chk("calib_lost_state", 64'(state_dbg), 64'(0));
        tick();
        cmp_all("t6a");
        calib_done = 1'b1;
        repeat (5) tick();
        send_frame(10, 1'b0, -1, -1);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("midreset");
        tick();
        rst_n = 1'b1;
        m_buf = 1'b0;
        m_done_buf = 1'b0;
        m_ovr = 1'b0;
        m_pending = 0;
        got_cmd.delete();
        exp_cmd.delete();
        got_data.delete();
        exp_data.delete();
        repeat (5) tick();
        send_frame(40, 1'b1, -1, -1);
        wait_frames();
        cmp_all("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
